// File: rtl/core_if_id_buf_pkg.sv
// Shared IF/ID buffer definitions: core-wide defines, state encoding and a saturating-increment helper.
// The optional performance counters are built only when CORE_IF_ID_PERF_EN is defined.
`ifndef CPU_PC_SIZE
`define CPU_PC_SIZE 32
`endif
`ifndef CPU_INSTR_SIZE
`define CPU_INSTR_SIZE 32
`endif
`ifndef CPU_NOP_INSTR
`define CPU_NOP_INSTR 32'h0000_0013
`endif
`ifndef IFID_EMPTY
`define IFID_EMPTY 2'd0
`define IFID_ONE   2'd1
`define IFID_FULL  2'd2
`endif

package core_if_id_buf_pkg;

    localparam int IFID_PC_W    = `CPU_PC_SIZE;
    localparam int IFID_INSTR_W = `CPU_INSTR_SIZE;

    typedef enum logic [1:0] {
        ST_EMPTY = `IFID_EMPTY,
        ST_ONE   = `IFID_ONE,
        ST_FULL  = `IFID_FULL
    } ifid_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/core_if_id_buf_if.sv
// Fetch-to-decode handshake bundle; slave is the buffer side, master the fetch/decode side.
interface core_if_id_buf_if
    import core_if_id_buf_pkg::*;
#(
    parameter int PC_W    = IFID_PC_W,
    parameter int INSTR_W = IFID_INSTR_W
);
    logic [PC_W-1:0]    pc_i;
    logic [INSTR_W-1:0] instr_i;
    logic               valid_i;
    logic               ready_o;
    logic [PC_W-1:0]    pc_o;
    logic [INSTR_W-1:0] instr_o;
    logic               valid_o;
    logic               ready_i;
    logic               flush_i;

    modport slave (
        input  pc_i, instr_i, valid_i, ready_i, flush_i,
        output ready_o, pc_o, instr_o, valid_o
    );

    modport master (
        output pc_i, instr_i, valid_i, ready_i, flush_i,
        input  ready_o, pc_o, instr_o, valid_o
    );
endinterface

// File: rtl/core_if_id_perf.sv
// Saturating stall and flush event counters for the IF/ID buffer (used under CORE_IF_ID_PERF_EN).
module core_if_id_perf
    import core_if_id_buf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_i ? sat_inc32(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_i ? sat_inc32(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
endmodule

// File: rtl/core_if_id_buf.sv
// IF/ID pipeline buffer: 2-entry skid buffer with registered upstream ready and redirect flush.
// Define CORE_IF_ID_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module core_if_id_buf
    import core_if_id_buf_pkg::*;
#(
    parameter int                 PC_W      = `CPU_PC_SIZE,
    parameter int                 INSTR_W   = `CPU_INSTR_SIZE,
    parameter logic [INSTR_W-1:0] NOP_INSTR = `CPU_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    core_if_id_buf_if.slave       bus
`ifdef CORE_IF_ID_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);
    ifid_state_e        state_q, state_d;
    logic               ready_q, ready_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               valid;
    logic               in_fire;
    logic               out_fire;

    assign valid    = (state_q != ST_EMPTY);
    assign in_fire  = bus.valid_i & ready_q;
    assign out_fire = valid & bus.ready_i;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (bus.flush_i) begin
            // Redirect wins over any handshake; pc_o keeps its last value.
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_pc_d    = bus.pc_i;
                        main_instr_d = bus.instr_i;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_pc_d    = bus.pc_i;
                        main_instr_d = bus.instr_i;
                    end else if (in_fire) begin
                        skid_pc_d    = bus.pc_i;
                        skid_instr_d = bus.instr_i;
                        state_d      = ST_FULL;
                    end else if (out_fire) begin
                        main_instr_d = NOP_INSTR;
                        state_d      = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        state_d      = ST_ONE;
                    end
                end
                default: begin
                    main_instr_d = NOP_INSTR;
                    state_d      = ST_EMPTY;
                end
            endcase
        end
        ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            ready_q      <= 1'b1;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign bus.valid_o = valid;
    assign bus.ready_o = ready_q;
    assign bus.pc_o    = main_pc_q;
    assign bus.instr_o = main_instr_q;

`ifdef CORE_IF_ID_PERF_EN
    core_if_id_perf u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (valid & ~bus.ready_i),
        .flush_i     (bus.flush_i),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`endif
endmodule

// File: tb/tb_core_if_id_buf.sv
// Directed table-driven bench for core_if_id_buf; counter checks are built when CORE_IF_ID_PERF_EN is defined.
module tb_core_if_id_buf;
    import core_if_id_buf_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h00A0_0093;
    localparam logic [31:0] IB  = 32'h00B0_0113;
    localparam logic [31:0] IC  = 32'h00C0_0193;
    localparam int          NV  = 24;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        ready;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[NV];

    core_if_id_buf_if #(.PC_W(32), .INSTR_W(32)) bus ();

`ifdef CORE_IF_ID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    core_if_id_buf dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    core_if_id_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic rd, input logic fl,
                                input logic [31:0] pc, input logic [31:0] ins,
                                input logic ev, input logic er,
                                input logic [31:0] epc, input logic [31:0] eins);
        vec_t t;
        t.rst = r; t.valid = v; t.ready = rd; t.flush = fl; t.pc = pc; t.instr = ins;
        t.exp_valid = ev; t.exp_ready = er; t.exp_pc = epc; t.exp_instr = eins;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic rd, input logic fl,
                        input logic [31:0] pc, input logic [31:0] ins);
        rst         = r;
        bus.valid_i = v;
        bus.ready_i = rd;
        bus.flush_i = fl;
        bus.pc_i    = pc;
        bus.instr_i = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int idx, input logic ev, input logic er,
                             input logic [31:0] epc, input logic [31:0] eins);
        check({tag, ".valid_o"}, idx, {31'd0, bus.valid_o}, {31'd0, ev});
        check({tag, ".ready_o"}, idx, {31'd0, bus.ready_o}, {31'd0, er});
        check({tag, ".pc_o"},    idx, bus.pc_o, epc);
        check({tag, ".instr_o"}, idx, bus.instr_o, eins);
    endtask

    initial begin
        //            rst v  rdy fl  pc          instr    ev  er  exp_pc      exp_instr
        vecs[0]  = mk(1, 1, 1, 0, 32'h40,  IA,  0, 1, 32'h0,   NOP);
        vecs[1]  = mk(1, 1, 1, 0, 32'h40,  IA,  0, 1, 32'h0,   NOP);
        vecs[2]  = mk(0, 1, 1, 0, 32'h0,   IA,  1, 1, 32'h0,   IA);
        vecs[3]  = mk(0, 1, 1, 0, 32'h4,   IB,  1, 1, 32'h4,   IB);
        vecs[4]  = mk(0, 1, 1, 0, 32'h8,   IC,  1, 1, 32'h8,   IC);
        vecs[5]  = mk(0, 0, 1, 0, 32'h0,   IA,  0, 1, 32'h8,   NOP);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,   IA,  1, 1, 32'h0,   IA);
        vecs[7]  = mk(0, 1, 0, 0, 32'h4,   IB,  1, 0, 32'h0,   IA);
        vecs[8]  = mk(0, 1, 0, 0, 32'h8,   IC,  1, 0, 32'h0,   IA);
        vecs[9]  = mk(0, 0, 1, 0, 32'h0,   IA,  1, 1, 32'h4,   IB);
        vecs[10] = mk(0, 0, 1, 0, 32'h0,   IA,  0, 1, 32'h4,   NOP);
        vecs[11] = mk(0, 1, 0, 0, 32'h10,  IA,  1, 1, 32'h10,  IA);
        vecs[12] = mk(0, 1, 0, 0, 32'h14,  IB,  1, 0, 32'h10,  IA);
        vecs[13] = mk(0, 1, 0, 1, 32'h100, IC,  0, 1, 32'h10,  NOP);
        vecs[14] = mk(0, 0, 0, 0, 32'h0,   IA,  0, 1, 32'h10,  NOP);
        vecs[15] = mk(0, 1, 1, 0, 32'h20,  IA,  1, 1, 32'h20,  IA);
        vecs[16] = mk(0, 1, 1, 1, 32'h24,  IB,  0, 1, 32'h20,  NOP);
        vecs[17] = mk(0, 1, 1, 0, 32'h28,  IC,  1, 1, 32'h28,  IC);
        vecs[18] = mk(0, 0, 1, 0, 32'h0,   IA,  0, 1, 32'h28,  NOP);
        vecs[19] = mk(0, 1, 0, 0, 32'h30,  IA,  1, 1, 32'h30,  IA);
        vecs[20] = mk(0, 1, 0, 0, 32'h34,  IB,  1, 0, 32'h30,  IA);
        vecs[21] = mk(1, 1, 0, 0, 32'h38,  IC,  0, 1, 32'h0,   NOP);
        vecs[22] = mk(0, 1, 0, 0, 32'h3c,  IB,  1, 1, 32'h3c,  IB);
        vecs[23] = mk(0, 0, 1, 0, 32'h0,   IA,  0, 1, 32'h3c,  NOP);

        rst = 1'b1;
        bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.flush_i = 1'b0;
        bus.pc_i = '0; bus.instr_i = '0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].ready, vecs[i].flush, vecs[i].pc, vecs[i].instr);
            check_out("vec", i, vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_pc, vecs[i].exp_instr);
        end

        // Long back-to-back stream: every pair appears one cycle later with no bubble.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0, 32'h200 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            check_out("stream", i, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        end
        step(0, 0, 1, 0, 32'h0, 32'h0);
        check_out("stream_end", 0, 1'b0, 1'b1, 32'h21c, NOP);

`ifdef CORE_IF_ID_PERF_EN
        step(0, 1, 0, 0, 32'h300, IA);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 1, 32'h0, 32'h0);
        step(0, 0, 1, 1, 32'h0, 32'h0);
        check("stall_cnt", 0, stall_cnt, 32'd5);
        check("flush_cnt", 0, flush_cnt, 32'd2);
        step(1, 0, 1, 0, 32'h0, 32'h0);
        check("stall_cnt_rst", 0, stall_cnt, 32'd0);
        check("flush_cnt_rst", 0, flush_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
